irq_priority_ctrl: RTL and testbench

Interrupt request front-end for the encoder family. It samples WIDTH raw request lines and turns each line into a pending bit, either edge-triggered or level-sensitive. It masks the pending bits and resolves the highest-index pending line to a binary ID, using the same MSB-wins rule as the priority encoders. It then presents that ID to a consumer through a request/acknowledge/end-of-interrupt handshake and tracks a single in-service interrupt.

---
 rtl/irq_priority_ctrl_if.sv | 36 +++
 rtl/irq_priority_ctrl.sv | 113 +++++++++++
 tb/tb_irq_priority_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_priority_ctrl_if.sv
// Handshake and configuration bundle for irq_priority_ctrl.
//   irq_in     raw request lines, synchronous to clk
//   edge_mode  per line: 1 = rising-edge triggered, 0 = level-sensitive
//   mask       per line: 1 = enabled, 0 = blocked (pending still records)
//   int_ack    consumer accepts the presented ID
//   eoi        consumer finished servicing
//   int_req    an interrupt is being presented
//   int_id     ID of the presented or in-service line
//   pending    registered pending bits
//   in_service an acknowledged interrupt awaits eoi
// master: the consumer side. slave: the controller.
interface irq_priority_ctrl_if #(
  parameter int WIDTH = 8
) ();
  localparam int ID_W = $clog2(WIDTH);

  logic [WIDTH-1:0] irq_in;
  logic [WIDTH-1:0] edge_mode;
  logic [WIDTH-1:0] mask;
  logic             int_ack;
  logic             eoi;
  logic             int_req;
  logic [ID_W-1:0]  int_id;
  logic [WIDTH-1:0] pending;
  logic             in_service;

  modport master (
    output irq_in, edge_mode, mask, int_ack, eoi,
    input  int_req, int_id, pending, in_service
  );

  modport slave (
    input  irq_in, edge_mode, mask, int_ack, eoi,
    output int_req, int_id, pending, in_service
  );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Interrupt request front-end: converts WIDTH raw request lines into pending
// bits (edge or level per line), masks them, resolves the highest-index active
// line to a binary ID and presents it via req/ack/eoi with a single
// in-service slot (no nesting).
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    irq_priority_ctrl_if.slave (see interface file for signal list)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing presented; waits for any active (pending & mask) line
// REQ     | int_req high; int_id follows the highest active line
// SERVICE | acknowledged; in_service high until eoi
module irq_priority_ctrl #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst_n,
  irq_priority_ctrl_if.slave bus
);
  localparam int ID_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] irq_prev;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] pending_nxt;
  logic [ID_W-1:0]  sel;
  logic             act_any;
  logic             ack_take;

  assign act     = bus.pending & bus.mask;
  assign act_any = |act;

  // MSB wins: later (higher) indices overwrite lower ones.
  always_comb begin
    sel = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (act[i]) sel = ID_W'(i);
    end
  end

  // An ack only counts in REQ while something is still active; if the active
  // set vanished this cycle the FSM falls back to IDLE instead.
  assign ack_take = (state == REQ) && act_any && bus.int_ack;

  always_comb begin
    edge_clr = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_clr[i] = ack_take && (bus.int_id == ID_W'(i));
    end
  end

  assign edge_set = bus.irq_in & ~irq_prev;

  // A new edge wins over a same-cycle ack clear so the arrival is not lost.
  assign pending_nxt = (bus.edge_mode & (edge_set | (bus.pending & ~edge_clr)))
                     | (~bus.edge_mode & bus.irq_in);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_prev       <= '0;
      bus.pending    <= '0;
      state          <= IDLE;
      bus.int_req    <= 1'b0;
      bus.int_id     <= '0;
      bus.in_service <= 1'b0;
    end else begin
      irq_prev    <= bus.irq_in;
      bus.pending <= pending_nxt;
      case (state)
        IDLE: begin
          if (act_any) begin
            state       <= REQ;
            bus.int_req <= 1'b1;
            bus.int_id  <= sel;
          end
        end
        REQ: begin
          if (!act_any) begin
            state       <= IDLE;
            bus.int_req <= 1'b0;
          end else if (bus.int_ack) begin
            state          <= SERVICE;
            bus.int_req    <= 1'b0;
            bus.in_service <= 1'b1;
          end else begin
            bus.int_id <= sel;
          end
        end
        SERVICE: begin
          if (bus.eoi) begin
            state          <= IDLE;
            bus.in_service <= 1'b0;
          end
        end
        default: begin
          state          <= IDLE;
          bus.int_req    <= 1'b0;
          bus.in_service <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Scoreboard bench for irq_priority_ctrl: each stimulus cycle runs a
// behavioural model and queues the expected post-edge outputs; a monitor
// pops and compares after every rising edge.
module tb_irq_priority_ctrl;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  irq_priority_ctrl_if #(.WIDTH(WIDTH)) bus ();
  irq_priority_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic       req;
    logic [2:0] id;
    logic [7:0] pend;
    logic       svc;
  } snap_t;

  snap_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam int PH_QUIET = 0, PH_OFFER = 1, PH_BUSY = 2;
  int         m_phase = PH_QUIET;
  int         m_id = 0;
  logic [7:0] m_prev = '0;
  logic [7:0] m_pend = '0;

  // index of the most significant set bit of a nonzero value
  function automatic int highest(int v);
    return $clog2(v + 1) - 1;
  endfunction

  function automatic snap_t dut_snap();
    return {bus.int_req, bus.int_id, bus.pending, bus.in_service};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_cycle(logic [7:0] irq, logic [7:0] em, logic [7:0] mk,
                             logic ack, logic e);
    logic [7:0] act;
    logic [7:0] nxt;
    bit taken;
    act   = m_pend & mk;
    taken = (m_phase == PH_OFFER) && (act != 0) && ack;
    for (int i = 0; i < 8; i++) begin
      if (em[i]) nxt[i] = (irq[i] && !m_prev[i]) || (m_pend[i] && !(taken && m_id == i));
      else       nxt[i] = irq[i];
    end
    case (m_phase)
      PH_QUIET: if (act != 0) begin m_phase = PH_OFFER; m_id = highest(int'(act)); end
      PH_OFFER: begin
        if (act == 0)  m_phase = PH_QUIET;
        else if (ack)  m_phase = PH_BUSY;
        else           m_id = highest(int'(act));
      end
      default: if (e) m_phase = PH_QUIET;
    endcase
    m_prev = irq;
    m_pend = nxt;
    sb.push_back({(m_phase == PH_OFFER), m_id[2:0], m_pend, (m_phase == PH_BUSY)});
  endtask

  // drive one cycle at the falling edge, return 2 time units after the rising edge
  task automatic step(logic [7:0] irq, logic [7:0] em, logic [7:0] mk,
                      logic ack, logic e);
    @(negedge clk);
    bus.irq_in    = irq;
    bus.edge_mode = em;
    bus.mask      = mk;
    bus.int_ack   = ack;
    bus.eoi       = e;
    model_cycle(irq, em, mk, ack, e);
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk({tag, "_int_req"}, 32'(bus.int_req), 0);
    chk({tag, "_int_id"}, 32'(bus.int_id), 0);
    chk({tag, "_pending"}, 32'(bus.pending), 0);
    chk({tag, "_in_service"}, 32'(bus.in_service), 0);
    m_phase = PH_QUIET;
    m_id    = 0;
    m_prev  = '0;
    m_pend  = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      snap_t e;
      snap_t g;
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        g = dut_snap();
        n_cmp++;
        if (g !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: got req=%b id=%0d pend=%h svc=%b, expected req=%b id=%0d pend=%h svc=%b",
                   $time, g.req, g.id, g.pend, g.svc, e.req, e.id, e.pend, e.svc);
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] cur_irq;
    logic [7:0] cur_em;
    logic [7:0] cur_mk;
    bus.irq_in    = 8'hFF;
    bus.edge_mode = 8'h00;
    bus.mask      = 8'hFF;
    bus.int_ack   = 1'b0;
    bus.eoi       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_int_req", 32'(bus.int_req), 0);
    chk("reset_int_id", 32'(bus.int_id), 0);
    chk("reset_pending", 32'(bus.pending), 0);
    chk("reset_in_service", 32'(bus.in_service), 0);
    bus.irq_in = 8'h01;
    rst_n = 1'b1;

    // level line 0 after reset
    step(8'h01, 8'h00, 8'hFF, 0, 0);
    step(8'h01, 8'h00, 8'hFF, 0, 0);
    chk("first_req", 32'(bus.int_req), 1);
    chk("first_id", 32'(bus.int_id), 0);
    step(8'h01, 8'h00, 8'hFF, 1, 0);
    step(8'h00, 8'h00, 8'hFF, 0, 1);
    step(8'h00, 8'h00, 8'hFF, 0, 0);

    // priority: bits 2 and 5 together
    step(8'h24, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    chk("prio_id5", 32'(bus.int_id), 5);
    step(8'h00, 8'hFF, 8'hFF, 1, 0);
    chk("prio_pend_after_ack5", 32'(bus.pending), 32'h04);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    chk("prio_id2_req", 32'(bus.int_req), 1);
    chk("prio_id2", 32'(bus.int_id), 2);
    step(8'h00, 8'hFF, 8'hFF, 1, 0);
    chk("prio_pend_after_ack2", 32'(bus.pending), 32'h00);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);

    // preemption: 1 then 6 before ack
    step(8'h02, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    chk("preempt_id1", 32'(bus.int_id), 1);
    step(8'h40, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    chk("preempt_id6", 32'(bus.int_id), 6);
    step(8'h00, 8'hFF, 8'hFF, 1, 0);
    chk("preempt_pend", 32'(bus.pending), 32'h02);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 1, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);

    // masking
    step(8'h08, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hF7, 0, 0);
    chk("mask_drop_req", 32'(bus.int_req), 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    chk("mask_restore_req", 32'(bus.int_req), 1);
    chk("mask_restore_id", 32'(bus.int_id), 3);
    step(8'h00, 8'hFF, 8'hFF, 1, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);

    // level line 4 held through ack and eoi
    step(8'h10, 8'hEF, 8'hFF, 0, 0);
    step(8'h10, 8'hEF, 8'hFF, 0, 0);
    step(8'h10, 8'hEF, 8'hFF, 1, 0);
    chk("level_pend_kept", 32'(bus.pending[4]), 1);
    step(8'h10, 8'hEF, 8'hFF, 0, 1);
    step(8'h10, 8'hEF, 8'hFF, 0, 0);
    chk("level_rereq", 32'(bus.int_req), 1);
    chk("level_rereq_id", 32'(bus.int_id), 4);
    step(8'h10, 8'hEF, 8'hFF, 1, 0);
    step(8'h00, 8'hEF, 8'hFF, 0, 1);
    // edge line 4 held high: one request only
    step(8'h10, 8'hFF, 8'hFF, 0, 0);
    step(8'h10, 8'hFF, 8'hFF, 0, 0);
    step(8'h10, 8'hFF, 8'hFF, 1, 0);
    step(8'h10, 8'hFF, 8'hFF, 0, 1);
    step(8'h10, 8'hFF, 8'hFF, 0, 0);
    step(8'h10, 8'hFF, 8'hFF, 0, 0);
    chk("edge_no_rereq", 32'(bus.int_req), 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);

    // boundaries
    step(8'h00, 8'hFF, 8'hFF, 1, 0);
    chk("ack_idle_ignored", 32'(bus.in_service), 0);
    step(8'h01, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);
    chk("eoi_req_ignored", 32'(bus.int_req), 1);
    step(8'h00, 8'hFF, 8'hFF, 1, 1);
    chk("ack_eoi_service", 32'(bus.in_service), 1);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);
    step(8'h08, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    step(8'h08, 8'hFF, 8'hFF, 1, 0);
    chk("set_clr_same_cycle", 32'(bus.pending[3]), 1);
    step(8'h00, 8'hFF, 8'hFF, 0, 1);
    step(8'h00, 8'hFF, 8'hFF, 0, 0);
    step(8'h00, 8'hFF, 8'hFF, 1, 0);
    step(8'h24, 8'hFF, 8'hFF, 0, 0);
    do_reset("rst_in_service");

    // randomized traffic
    cur_irq = '0;
    cur_em  = 8'hFF;
    cur_mk  = 8'hFF;
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 399) == 0) do_reset("rand_rst");
      cur_irq = cur_irq ^ 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 39) == 0) cur_em = 8'($urandom);
      cur_mk = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'hFF;
      step(cur_irq, cur_em, cur_mk, ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
